// File: rtl/alu_sched_pkg.sv
// Shared constants for the ALU operation scheduler: opcodes, FSM states, requester count.
// Used by alu_core and alu_op_scheduler.
package alu_sched_pkg;

   localparam int unsigned NUM_REQ = 2;

   localparam logic [1:0] OP_AND = 2'b00;
   localparam logic [1:0] OP_OR  = 2'b01;
   localparam logic [1:0] OP_ADD = 2'b10;
   localparam logic [1:0] OP_SUB = 2'b11;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      HOLD = 2'd2
   } state_e;

endpackage

// File: rtl/alu_core.sv
// Combinational N-bit AND/OR/ADD/SUB unit. cout_o is the add carry-out or the subtract
// borrow (a < b unsigned), and is 0 for the bitwise operations.
module alu_core
   import alu_sched_pkg::*;
#(
   parameter int unsigned N = 4
) (
   input  logic [1:0]   op_i,
   input  logic [N-1:0] a_i,
   input  logic [N-1:0] b_i,
   output logic [N-1:0] y_o,
   output logic         cout_o
);

   logic [N-1:0] or_bits;
   logic [N:0]   sum;
   logic [N:0]   diff;

   for (genvar i = 0; i < N; i++) begin : g_or
      assign or_bits[i] = a_i[i] | b_i[i];
   end

   // The extra top bit holds the carry for add and the borrow for subtract.
   assign sum  = {1'b0, a_i} + {1'b0, b_i};
   assign diff = {1'b0, a_i} - {1'b0, b_i};

   always_comb begin
      y_o    = '0;
      cout_o = 1'b0;
      case (op_i)
         OP_AND: y_o = a_i & b_i;
         OP_OR:  y_o = or_bits;
         OP_ADD: begin
            y_o    = sum[N-1:0];
            cout_o = sum[N];
         end
         OP_SUB: begin
            y_o    = diff[N-1:0];
            cout_o = diff[N];
         end
         default: y_o = '0;
      endcase
   end

endmodule

// File: rtl/alu_op_scheduler.sv
// Two-requester round-robin scheduler sharing one ALU: IDLE grants, EXEC computes, HOLD presents.
// Define ALU_OP_SCHEDULER_FLAGS_EN to add the registered zero and carry outputs.
module alu_op_scheduler
   import alu_sched_pkg::*;
#(
   parameter int unsigned N = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               req0,
   input  logic [1:0]         op0,
   input  logic [N-1:0]       a0,
   input  logic [N-1:0]       b0,
   input  logic               req1,
   input  logic [1:0]         op1,
   input  logic [N-1:0]       a1,
   input  logic [N-1:0]       b1,
   output logic [NUM_REQ-1:0] gnt,
   output logic [N-1:0]       res,
   output logic               res_id,
   output logic               res_valid,
`ifdef ALU_OP_SCHEDULER_FLAGS_EN
   output logic               zero,
   output logic               carry,
`endif
   input  logic               res_ready
);

   state_e       state_q, state_d;
   logic         ptr_q, ptr_d;
   logic [1:0]   op_q, op_d;
   logic [N-1:0] a_q, a_d;
   logic [N-1:0] b_q, b_d;
   logic         id_q, id_d;
   logic [N-1:0] res_q, res_d;
   logic         res_id_q, res_id_d;
   logic [N-1:0] alu_y;
   logic         alu_cout;

   alu_core #(.N(N)) u_alu (
      .op_i   (op_q),
      .a_i    (a_q),
      .b_i    (b_q),
      .y_o    (alu_y),
      .cout_o (alu_cout)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (req0 || req1) state_d = EXEC;
         EXEC:    state_d = HOLD;
         HOLD:    if (res_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // ptr_q = 1 favours requester 1 on contention; a lone request wins regardless.
   always_comb begin
      gnt       = '0;
      res_valid = 1'b0;
      case (state_q)
         IDLE: begin
            if (!rst) begin
               if (req0 && (!req1 || !ptr_q)) gnt = 2'b01;
               else if (req1)                 gnt = 2'b10;
            end
         end
         HOLD:    res_valid = 1'b1;
         default: ;
      endcase
   end

   always_comb begin
      ptr_d    = ptr_q;
      op_d     = op_q;
      a_d      = a_q;
      b_d      = b_q;
      id_d     = id_q;
      res_d    = res_q;
      res_id_d = res_id_q;
      if (gnt != '0) begin
         ptr_d = gnt[0];
         id_d  = gnt[1];
         op_d  = gnt[1] ? op1 : op0;
         a_d   = gnt[1] ? a1  : a0;
         b_d   = gnt[1] ? b1  : b0;
      end
      if (state_q == EXEC) begin
         res_d    = alu_y;
         res_id_d = id_q;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr_q    <= 1'b0;
         op_q     <= '0;
         a_q      <= '0;
         b_q      <= '0;
         id_q     <= 1'b0;
         res_q    <= '0;
         res_id_q <= 1'b0;
      end else begin
         ptr_q    <= ptr_d;
         op_q     <= op_d;
         a_q      <= a_d;
         b_q      <= b_d;
         id_q     <= id_d;
         res_q    <= res_d;
         res_id_q <= res_id_d;
      end
   end

   assign res    = res_q;
   assign res_id = res_id_q;

`ifdef ALU_OP_SCHEDULER_FLAGS_EN
   logic zero_q, zero_d;
   logic carry_q, carry_d;

   always_comb begin
      zero_d  = zero_q;
      carry_d = carry_q;
      if (state_q == EXEC) begin
         zero_d  = (alu_y == '0);
         carry_d = alu_cout;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         zero_q  <= 1'b0;
         carry_q <= 1'b0;
      end else begin
         zero_q  <= zero_d;
         carry_q <= carry_d;
      end
   end

   assign zero  = zero_q;
   assign carry = carry_q;
`else
   logic unused_cout;
   assign unused_cout = alu_cout;
`endif

endmodule
